// File: rtl/ddr_arb_pkg.sv
// Shared types and default constants for the DDR command arbiter.
package ddr_arb_pkg;

    localparam int DEF_ADDR_WIDTH       = 24;
    localparam int DEF_LEN_WIDTH        = 4;
    localparam int DEF_REFRESH_INTERVAL = 780;
    localparam int DEF_MAX_PENDING      = 8;
    localparam int DEF_TIMEOUT_CYCLES   = 4096;

    typedef enum logic [1:0] {
        CMD_READ    = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_REFRESH = 2'd2
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Refresh interval timer with saturating pending-refresh counter and a
// sticky overflow flag for ticks that arrive while already saturated.
module ddr_refresh_timer
    import ddr_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING,
    localparam int CNT_W           = cnt_width(REFRESH_INTERVAL),
    localparam int PEND_W          = cnt_width(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_i,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              tick;

    // Down-counter reload on terminal count; a tick and an accepted
    // refresh in the same cycle cancel each other.
    always_comb begin
        tick   = (cnt_q == '0);
        cnt_d  = tick ? CNT_W'(REFRESH_INTERVAL - 1) : cnt_q - 1'b1;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !dec_i) begin
            if (pend_q == PEND_W'(MAX_PENDING)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec_i && !tick && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Timer, pending count and overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= CNT_W'(REFRESH_INTERVAL - 1);
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Two-port round-robin arbiter in front of a single-command DDR controller,
// with interleaved auto-refresh scheduling.
// Optional: define ARB_TIMEOUT_EN to add a WAIT_DONE watchdog and the
// sticky timeout_err output.
//
// state     | meaning
// IDLE      | choose refresh or a requester; ready pulses here only
// ISSUE     | command fields held, ctrl_cmd_valid high until accepted
// WAIT_DONE | waiting for the controller's done pulse
module ddr_cmd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH,
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_write,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_write,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    output logic                  ctrl_cmd_valid,
    input  logic                  ctrl_cmd_ready,
    output logic [1:0]            ctrl_cmd_kind,
    output logic [ADDR_WIDTH-1:0] ctrl_cmd_addr,
    output logic [LEN_WIDTH-1:0]  ctrl_cmd_len,
    output logic                  ctrl_cmd_src,
    input  logic                  ctrl_done,
    output logic                  refresh_overflow,
    output logic                  busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    localparam int PEND_W = cnt_width(MAX_PENDING + 1);

    arb_state_e            state_q, state_d;
    cmd_kind_e             kind_q, kind_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  src_q, src_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant;
    logic                  refresh_ack;
    logic [PEND_W-1:0]     pending;
    logic                  pend_full;
    logic                  pend_nz;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_err_q, tmo_err_d;
    logic             tmo_hit;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    ddr_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .dec_i      (refresh_ack),
        .pending_o  (pending),
        .overflow_o (refresh_overflow)
    );

    assign pend_full = (pending == PEND_W'(MAX_PENDING));
    assign pend_nz   = (pending != '0);

    // Next-state, command capture and handshake decode.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        len_d        = len_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        grant        = 1'b0;
        refresh_ack  = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_err_d    = tmo_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Refresh wins when saturated, or whenever no traffic is waiting.
                if (pend_full || (pend_nz && !req0_valid && !req1_valid)) begin
                    kind_d  = CMD_REFRESH;
                    addr_d  = '0;
                    len_d   = '0;
                    src_d   = 1'b0;
                    state_d = ST_ISSUE;
                end else if (req0_valid || req1_valid) begin
                    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    last_grant_d = grant;
                    src_d        = grant;
                    state_d      = ST_ISSUE;
                    if (grant) begin
                        req1_ready = 1'b1;
                        kind_d     = req1_write ? CMD_WRITE : CMD_READ;
                        addr_d     = req1_addr;
                        len_d      = req1_len;
                    end else begin
                        req0_ready = 1'b1;
                        kind_d     = req0_write ? CMD_WRITE : CMD_READ;
                        addr_d     = req0_addr;
                        len_d      = req0_len;
                    end
                end
            end
            ST_ISSUE: begin
                if (ctrl_cmd_ready) begin
                    state_d     = ST_WAIT_DONE;
                    refresh_ack = (kind_q == CMD_REFRESH);
                end
            end
            ST_WAIT_DONE: begin
                if (ctrl_done) begin
                    state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    tmo_err_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured command registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kind_q       <= CMD_READ;
            addr_q       <= '0;
            len_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counts only while parked in WAIT_DONE.
    assign tmo_d = ((state_q == ST_WAIT_DONE) && (state_d == ST_WAIT_DONE)) ? tmo_q + 1'b1 : '0;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`endif

    assign ctrl_cmd_valid = (state_q == ST_ISSUE);
    assign ctrl_cmd_kind  = kind_q;
    assign ctrl_cmd_addr  = addr_q;
    assign ctrl_cmd_len   = len_q;
    assign ctrl_cmd_src   = src_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed bench for ddr_cmd_arbiter: scoreboard of expected commands,
// refresh timing tracked from the reset release cycle.
module tb_ddr_cmd_arbiter;

    localparam int RI = 780;
    localparam int MP = 8;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] addr;
        logic [3:0]  len;
        logic        src;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [23:0] req0_addr = '0, req1_addr = '0;
    logic        req0_write = 0, req1_write = 0;
    logic [3:0]  req0_len = '0, req1_len = '0;
    logic        ctrl_cmd_valid;
    logic        ctrl_cmd_ready = 0;
    logic [1:0]  ctrl_cmd_kind;
    logic [23:0] ctrl_cmd_addr;
    logic [3:0]  ctrl_cmd_len;
    logic        ctrl_cmd_src;
    logic        ctrl_done = 0;
    logic        refresh_overflow;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   pend_m = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(
        .ADDR_WIDTH       (24),
        .LEN_WIDTH        (4),
        .REFRESH_INTERVAL (RI),
        .MAX_PENDING      (MP)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES   (16)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_addr        (req0_addr),
        .req0_write       (req0_write),
        .req0_len         (req0_len),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_addr        (req1_addr),
        .req1_write       (req1_write),
        .req1_len         (req1_len),
        .ctrl_cmd_valid   (ctrl_cmd_valid),
        .ctrl_cmd_ready   (ctrl_cmd_ready),
        .ctrl_cmd_kind    (ctrl_cmd_kind),
        .ctrl_cmd_addr    (ctrl_cmd_addr),
        .ctrl_cmd_len     (ctrl_cmd_len),
        .ctrl_cmd_src     (ctrl_cmd_src),
        .ctrl_done        (ctrl_done),
        .refresh_overflow (refresh_overflow),
        .busy             (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: returns 1 time unit after the rising edge; tracks refresh ticks.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if ((cyc_n % RI == 0) && (pend_m < MP)) pend_m++;
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [23:0] a, input logic [3:0] l, input logic s);
        exp_t e;
        e.kind = k; e.addr = a; e.len = l; e.src = s;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; ctrl_cmd_ready = 0; ctrl_done = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc_n = 0;
        pend_m = 0;
        sb.delete();
    endtask

    // Controller model: wait for a command, check it against the scoreboard,
    // accept it, then return done one cycle later.
    task automatic serve();
        int   n = 0;
        exp_t e;
        while (ctrl_cmd_valid !== 1'b1 && n < 2000) begin
            cyc();
            n++;
        end
        #1;
        chk("cmd_valid_seen", ctrl_cmd_valid, 1);
        chk("issue_no_ready", req0_ready | req1_ready, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("cmd_kind", ctrl_cmd_kind, e.kind);
            chk("cmd_addr", ctrl_cmd_addr, e.addr);
            chk("cmd_len", ctrl_cmd_len, e.len);
            chk("cmd_src", ctrl_cmd_src, e.src);
        end
        ctrl_cmd_ready = 1;
        cyc();
        ctrl_cmd_ready = 0;
        #1;
        chk("wait_valid_low", ctrl_cmd_valid, 0);
        chk("wait_busy", busy, 1);
        chk("wait_no_ready", req0_ready | req1_ready, 0);
        ctrl_done = 1;
        cyc();
        ctrl_done = 0;
        #1;
        chk("done_idle", busy, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic lg;
        logic exp_g;
        int   iter;

        // Reset state, asynchronous before any clock edge.
        #3;
        chk("rst_valid", ctrl_cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", refresh_overflow, 0);
        chk("rst_kind", ctrl_cmd_kind, 0);
        chk("rst_addr", ctrl_cmd_addr, 0);
        chk("rst_len", ctrl_cmd_len, 0);
        chk("rst_src", ctrl_cmd_src, 0);
        chk("rst_ready", req0_ready | req1_ready, 0);

        // Single request: ready same cycle, command next cycle, done in ISSUE ignored.
        do_reset();
        req0_addr = 24'h001234; req0_write = 0; req0_len = 4'd3; req0_valid = 1;
        #1;
        chk("A_ready0", req0_ready, 1);
        chk("A_ready1", req1_ready, 0);
        push_exp(2'd0, 24'h001234, 4'd3, 1'b0);
        cyc();
        req0_valid = 0;
        #1;
        chk("A_valid_t1", ctrl_cmd_valid, 1);
        ctrl_done = 1;
        cyc();
        ctrl_done = 0;
        #1;
        chk("A_done_ignored", ctrl_cmd_valid, 1);
        serve();

        // Contention: both ports held valid, grants alternate starting at port 0.
        do_reset();
        req0_addr = 24'hABCDEF; req0_write = 1; req0_len = 4'd5;
        req1_addr = 24'h000FFF; req1_write = 0; req1_len = 4'd15;
        req0_valid = 1; req1_valid = 1;
        lg = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = ~lg;
            chk("B_ready0", req0_ready, exp_g == 1'b0);
            chk("B_ready1", req1_ready, exp_g == 1'b1);
            if (exp_g) push_exp(2'd0, 24'h000FFF, 4'd15, 1'b1);
            else       push_exp(2'd1, 24'hABCDEF, 4'd5, 1'b0);
            lg = exp_g;
            cyc();
            serve();
        end
        req0_valid = 0; req1_valid = 0;

        // Idle refresh, accepted in the same cycle as the next tick.
        do_reset();
        while (cyc_n < RI) cyc();
        #1;
        chk("R_not_yet", ctrl_cmd_valid, 0);
        cyc();
        #1;
        chk("R_valid", ctrl_cmd_valid, 1);
        push_exp(2'd2, 24'h0, 4'd0, 1'b0);
        while (cyc_n < 2 * RI - 1) cyc();
        #1;
        chk("R_held", ctrl_cmd_valid, 1);
        serve();
        push_exp(2'd2, 24'h0, 4'd0, 1'b0);
        serve();
        repeat (40) cyc();
        #1;
        chk("R_drained", ctrl_cmd_valid | busy, 0);
        chk("R_ovf", refresh_overflow, 0);

        // Postponement under continuous port-0 traffic.
        do_reset();
        req0_addr = 24'h000100; req0_write = 0; req0_len = 4'd1; req0_valid = 1;
        iter = 0;
        while (pend_m < MP && iter < 3000) begin
            #1;
            chk("P_grant0", req0_ready, 1);
            push_exp(2'd0, 24'h000100, 4'd1, 1'b0);
            cyc();
            serve();
            iter++;
        end
        chk("P_reached_max", pend_m, MP);
        #1;
        chk("P_preempt", req0_ready, 0);
        push_exp(2'd2, 24'h0, 4'd0, 1'b0);
        cyc();
        #1;
        chk("P_refresh_valid", ctrl_cmd_valid, 1);
        while (cyc_n < 9 * RI - 1) cyc();
        #1;
        chk("P_ovf_before", refresh_overflow, 0);
        cyc();
        #1;
        chk("P_ovf_after", refresh_overflow, 1);
        serve();
        req0_valid = 0;
        req1_addr = 24'hFEDCBA; req1_write = 1; req1_len = 4'd7; req1_valid = 1;
        #1;
        chk("P_below_max_grant", req1_ready, 1);
        cyc();
        req1_valid = 0;
        #1;
        chk("P_kind", ctrl_cmd_kind, 1);
        chk("P_src", ctrl_cmd_src, 1);
        ctrl_cmd_ready = 1;
        cyc();
        ctrl_cmd_ready = 0;
        #1;
        chk("M_busy_wait", busy, 1);

        // Reset mid WAIT_DONE: outputs clear without a clock edge.
        reset = 1'b1;
        #1;
        chk("M_busy", busy, 0);
        chk("M_valid", ctrl_cmd_valid, 0);
        chk("M_kind", ctrl_cmd_kind, 0);
        chk("M_addr", ctrl_cmd_addr, 0);
        chk("M_len", ctrl_cmd_len, 0);
        chk("M_src", ctrl_cmd_src, 0);
        chk("M_ovf", refresh_overflow, 0);

`ifdef ARB_TIMEOUT_EN
        // Done withheld: watchdog returns to IDLE after 16 cycles.
        do_reset();
        req0_addr = 24'h000042; req0_valid = 1;
        cyc();
        req0_valid = 0;
        ctrl_cmd_ready = 1;
        cyc();
        ctrl_cmd_ready = 0;
        repeat (15) cyc();
        #1;
        chk("T_busy_before", busy, 1);
        chk("T_err_before", timeout_err, 0);
        cyc();
        #1;
        chk("T_busy_after", busy, 0);
        chk("T_err_after", timeout_err, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
